uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, next generation of the housekeeper serial RX path.
//  Configurable data width, parity and stop bits; validated start bit; framing/parity errors.
//  Ready/valid output holding register with overrun detection, feeding the housekeeper cmd parser.
//  Asynchronous Rx pin is synchronised internally.
// PARAMETERS
//  BAUD_RATE    9600      line rate, bit/s
//  CLK_FREQ_HZ  12000000  Clk frequency, Hz; PERIOD=CLK_FREQ_HZ/BAUD_RATE, HALF=PERIOD/2
//  DATA_BITS    8         data bits per frame, legal 5..9
//  PARITY       0         0=none, 1=odd, 2=even
//  STOP_BITS    1         1 or 2
//  SYNC_STAGES  2         Rx synchroniser depth, >=2
// PORTS
//  Clk        in   1          clock
//  Rst        in   1          synchronous reset, active-high
//  Rx         in   1          serial line, idle high, async
//  RxD        out  DATA_BITS  received data, LSB = first bit on line
//  RxDValid   out  1          RxD/FrameErr/ParityErr valid; held until accepted
//  RxDReady   in   1          consumer accept; transfer when RxDValid&&RxDReady
//  FrameErr   out  1          stop bit sampled 0 (qualified by RxDValid)
//  ParityErr  out  1          parity mismatch (qualified by RxDValid; 0 if PARITY=0)
//  Overrun    out  1          1-cycle pulse: frame completed and dropped (holding reg full)
//  Busy       out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset (sync, Rst=1 at posedge Clk): all outputs 0, FSM->IDLE, bit/clk counters 0,
//    synchroniser flops ->1. Reset mid-frame aborts the frame, nothing delivered.
//  - Rx passes SYNC_STAGES flops -> rxs; rxs_d = rxs delayed 1 cycle.
//  - FSM IDLE/START/DATA/PARITY/STOP; each bit state counts clkCntr 0..PERIOD-1,
//    width $clog2(PERIOD); decision cycle D = HALF (HALF+1 with majority, see CONFIG).
//  - IDLE: falling edge (rxs_d=1 && rxs=0) -> START, clkCntr=0. Level low alone never starts.
//  - START: at D, sample=1 -> IDLE (glitch rejected); sample=0 -> continue; at PERIOD-1 -> DATA.
//  - DATA: at D shift sample into data shift reg LSB-first; at PERIOD-1 bitCntr++;
//    after DATA_BITS bits -> PARITY if PARITY!=0 else STOP.
//  - PARITY: at D, err = (^data ^ sample) != (PARITY==1); at PERIOD-1 -> STOP.
//  - STOP: at D of each stop bit, sample=0 sets frame error; STOP_BITS=2 waits to PERIOD-1
//    between them. At D of last stop bit: deliver frame, FSM->IDLE same cycle (no wait for end).
//  - Delivery (cycle after D of last stop bit): if !RxDValid or RxDReady -> load RxD,
//    FrameErr, ParityErr, RxDValid=1. Else -> Overrun=1 one cycle, new frame discarded,
//    held frame unchanged.
//  - Accept without new delivery: RxDValid&&RxDReady -> RxDValid=0 next cycle; RxD and
//    error flags keep value. Simultaneous accept+delivery: new frame loaded, RxDValid stays 1.
//  - Frame error still delivers data. Break (Rx held low): one frame with FrameErr; no
//    restart until Rx returns high and falls again.
//  - Elaboration: $error if DATA_BITS outside 5..9, PARITY>2, STOP_BITS not 1/2, PERIOD<8.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each bit sampled at HALF-1, HALF, HALF+1; 2-of-3 majority
//   is the bit value, decided at D=HALF+1. Rejects single-cycle glitches at mid-bit.
//  Undefined: single sample at D=HALF; no vote logic. Latency 1 cycle shorter.
// TESTING  (CLK_FREQ_HZ=12000000, BAUD_RATE=1000000 -> PERIOD=12, HALF=6)
//  8N1 0xA5, RxDReady=1 -> RxDValid 1 cycle, RxD=0xA5, FrameErr=0, ParityErr=0, Overrun=0.
//  Rx low 3 cycles then high, then 8N1 0x3C -> no delivery for glitch; RxD=0x3C, Busy 0 between.
//  PARITY=2, DATA_BITS=7, send 0x07 with parity bit 0 -> RxD=0x07, ParityErr=1; bit 1 -> 0.
//  8N1 0x55 stop=0, Rx held low 40 cycles, then high, then 0x12 -> one frame 0x55 FrameErr=1,
//   no spurious frame during break, then 0x12 clean.
//  RxDReady=0, send 0x11 then 0x22 -> Overrun pulse at 0x22 delivery, RxD=0x11 held;
//   RxDReady=1 1 cycle -> RxDValid=0. Repeat with Ready=1 at 0x22 delivery -> RxD=0x22, no Overrun.
//  Rst 1 cycle during data bit 4 of 0xFF -> all outputs 0, Busy=0; next frame 0x81 clean.
//  MAJORITY_EN: 1-cycle high glitch at HALF in data bit 0 of 0x00 -> RxD=0x00; without macro 0x01.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: synchronised Rx, validated start bit, parity/framing checks,
// ready/valid holding register with overrun pulse. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_cfg #(
  parameter int BAUD_RATE   = 9600,
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] RxD,
  output logic                 RxDValid,
  input  logic                 RxDReady,
  output logic                 FrameErr,
  output logic                 ParityErr,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int PERIOD = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF   = PERIOD / 2;
  localparam int CW     = $clog2(PERIOD);
  localparam int BW     = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC    = HALF + 1;
`else
  localparam int DEC    = HALF;
`endif
  localparam logic [CW-1:0] CNT_DEC  = CW'(DEC);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PERIOD < 8) begin : g_bad_period
      $error("uart_rx_cfg: CLK_FREQ_HZ/BAUD_RATE must be >= 8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx_cfg: SYNC_STAGES must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs_d_q, rxs;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   rxd_q, rxd_d;
  logic                   valid_q, valid_d;
  logic                   fe_q, fe_d;
  logic                   pe_q, pe_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;
  logic                   sample, at_dec, at_last, done;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], Rx};
  assign rxs    = sync_q[SYNC_STAGES-1];
  assign at_dec  = (cnt_q == CNT_DEC);
  assign at_last = (cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
  // Two early samples are kept; the third is the live synchroniser output at the decision cycle.
  logic [1:0] vote_q, vote_d;
  always_comb begin
    vote_d = vote_q;
    if (cnt_q == CW'(HALF - 1)) vote_d[0] = rxs;
    if (cnt_q == CW'(HALF))     vote_d[1] = rxs;
  end
  assign sample = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);
`else
  assign sample = rxs;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = at_last ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (rxs_d_q && !rxs) begin
          state_d = S_START;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (at_dec && sample) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_last) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_dec) shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
        if (at_last) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (at_dec) perr_d = ((^shreg_q) ^ sample) != (PARITY == 1);
        if (at_last) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_dec) begin
          if (!sample) ferr_d = 1'b1;
          // Hand the frame off at mid-bit of the last stop bit so a following start edge is not missed.
          if (stop_q == STOP_LAST) begin
            done    = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (at_last) begin
          stop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rxd_d   = rxd_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    ovr_d   = 1'b0;
    if (valid_q && RxDReady) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || RxDReady) begin
        rxd_d   = shreg_q;
        fe_d    = ferr_q | ~sample;
        pe_d    = perr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      rxs_d_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rxd_q   <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      vote_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      rxs_d_q <= rxs;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      rxd_q   <= rxd_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      vote_q  <= vote_d;
`endif
    end
  end

  assign RxD       = rxd_q;
  assign RxDValid  = valid_q;
  assign FrameErr  = fe_q;
  assign ParityErr = pe_q;
  assign Overrun   = ovr_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg at PERIOD=12: an 8N1 instance and a 7E1 instance share one Rx line.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  logic       clk = 1'b0;
  logic       rst, rx, rdy, rdy_p;
  logic [7:0] rxd;
  logic       vld, fe, pe, ovr, busy;
  logic [6:0] prxd;
  logic       pvld, pfe, ppe, povr, pbusy;

  int checks = 0;
  int fails  = 0;
  int vcnt   = 0;
  int ocnt   = 0;
  int v0, o0;

`ifdef UART_RX_MAJORITY_EN
  localparam int ROFS = 10;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int ROFS = 9;
  localparam logic [7:0] GLITCH_EXP = 8'h01;
`endif

  always #5 clk = ~clk;

  uart_rx_cfg #(.BAUD_RATE(1000000), .CLK_FREQ_HZ(12000000)) dut (
    .Clk(clk), .Rst(rst), .Rx(rx), .RxD(rxd), .RxDValid(vld), .RxDReady(rdy),
    .FrameErr(fe), .ParityErr(pe), .Overrun(ovr), .Busy(busy));

  uart_rx_cfg #(.BAUD_RATE(1000000), .CLK_FREQ_HZ(12000000), .DATA_BITS(7), .PARITY(2)) u_par (
    .Clk(clk), .Rst(rst), .Rx(rx), .RxD(prxd), .RxDValid(pvld), .RxDReady(rdy_p),
    .FrameErr(pfe), .ParityErr(ppe), .Overrun(povr), .Busy(pbusy));

  always @(negedge clk) begin
    if (vld) vcnt = vcnt + 1;
    if (ovr) ocnt = ocnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // bits[0] goes out first; optional one-cycle inversion and a one-cycle ready pulse in the last bit
  task automatic send(input logic [15:0] bits, input int nbits, input int g_idx, input int g_ofs,
                      input int r_ofs);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < 12; c++) begin
        rx = bits[b] ^ ((b == g_idx) && (c == g_ofs));
        if (r_ofs >= 0) rdy = (b == nbits - 1) && (c == r_ofs);
        tick(1);
      end
    end
  endtask

  function automatic logic [15:0] f8(input logic [7:0] d, input logic s);
    return {6'b0, s, d, 1'b0};
  endfunction

  function automatic logic [15:0] f7p(input logic [6:0] d, input logic p);
    return {6'b0, 1'b1, p, d, 1'b0};
  endfunction

  initial begin
    rst = 1'b1; rx = 1'b1; rdy = 1'b1; rdy_p = 1'b1;
    tick(3);
    chk("reset_valid", vld, 0);
    chk("reset_rxd", rxd, 0);
    chk("reset_fe", fe, 0);
    chk("reset_pe", pe, 0);
    chk("reset_ovr", ovr, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick(5);

    v0 = vcnt; o0 = ocnt;
    send(f8(8'hA5, 1'b1), 10, -1, 0, -1);
    tick(4);
    chk("a5_valid_cycles", vcnt - v0, 1);
    chk("a5_rxd", rxd, 8'hA5);
    chk("a5_fe", fe, 0);
    chk("a5_pe", pe, 0);
    chk("a5_ovr", ocnt - o0, 0);

    v0 = vcnt;
    rx = 1'b0; tick(3); rx = 1'b1; tick(20);
    chk("glitch_busy", busy, 0);
    chk("glitch_no_frame", vcnt - v0, 0);
    send(f8(8'h3C, 1'b1), 10, -1, 0, -1);
    tick(4);
    chk("3c_rxd", rxd, 8'h3C);
    chk("3c_valid_cycles", vcnt - v0, 1);

    send(f7p(7'h07, 1'b0), 10, -1, 0, -1);
    tick(4);
    chk("par_bad_rxd", prxd, 7'h07);
    chk("par_bad_pe", ppe, 1);
    send(f7p(7'h07, 1'b1), 10, -1, 0, -1);
    tick(4);
    chk("par_good_rxd", prxd, 7'h07);
    chk("par_good_pe", ppe, 0);

    v0 = vcnt;
    send(f8(8'h55, 1'b0), 10, -1, 0, -1);
    rx = 1'b0; tick(40); rx = 1'b1; tick(20);
    chk("brk_frames", vcnt - v0, 1);
    chk("brk_rxd", rxd, 8'h55);
    chk("brk_fe", fe, 1);
    send(f8(8'h12, 1'b1), 10, -1, 0, -1);
    tick(4);
    chk("post_brk_frames", vcnt - v0, 2);
    chk("post_brk_rxd", rxd, 8'h12);
    chk("post_brk_fe", fe, 0);

    rdy = 1'b0; o0 = ocnt;
    send(f8(8'h11, 1'b1), 10, -1, 0, -1);
    tick(4);
    send(f8(8'h22, 1'b1), 10, -1, 0, -1);
    tick(4);
    chk("ovr_pulses", ocnt - o0, 1);
    chk("ovr_rxd_held", rxd, 8'h11);
    chk("ovr_valid_held", vld, 1);
    rdy = 1'b1; tick(1); rdy = 1'b0;
    chk("accept_clears_valid", vld, 0);
    chk("accept_keeps_rxd", rxd, 8'h11);

    o0 = ocnt;
    send(f8(8'h11, 1'b1), 10, -1, 0, -1);
    tick(4);
    chk("sim_first_valid", vld, 1);
    send(f8(8'h22, 1'b1), 10, -1, 0, ROFS);
    tick(4);
    chk("sim_rxd", rxd, 8'h22);
    chk("sim_valid", vld, 1);
    chk("sim_no_ovr", ocnt - o0, 0);

    rx = 1'b0; tick(12);
    rx = 1'b1; tick(54);
    chk("midframe_busy", busy, 1);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_valid", vld, 0);
    chk("rst_rxd", rxd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pbusy", pbusy, 0);
    tick(60);
    chk("rst_idle_busy", busy, 0);
    rdy = 1'b1; v0 = vcnt;
    send(f8(8'h81, 1'b1), 10, -1, 0, -1);
    tick(4);
    chk("post_rst_rxd", rxd, 8'h81);
    chk("post_rst_frames", vcnt - v0, 1);
    chk("post_rst_fe", fe, 0);

    v0 = vcnt;
    send(f8(8'h00, 1'b1), 10, 1, 7, -1);
    tick(4);
    chk("midbit_glitch_rxd", rxd, GLITCH_EXP);
    chk("midbit_glitch_frames", vcnt - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
